adxl362_spi_responder: RTL
==========================

Name: adxl362_spi_responder

Overview:
- Simulation and bring-up model of the ADXL362 accelerometer; the SPI responder side of the accelerometer link.
- Connects to the ACL_SCLK/ACL_MOSI/ACL_CSN/ACL_MISO pins of the accelerometer controller.
- Decodes read and write commands, serves ID/status/data registers, holds the writable control registers.
- Feeds 12-bit acceleration samples supplied by the bench or a stimulus block, so the ball-movement path can be checked without hardware.

Parameters:
- DEVID_AD, 8'hAD, value returned at address 0x00.
- DEVID_MST, 8'h1D, value returned at address 0x01.
- PARTID, 8'hF2, value returned at address 0x02.
- SYNC_STAGES, 2, flip-flop depth of the SCLK/MOSI/CSN synchronizers (>=2).

Ports:
- CLK  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- SCLK  input  1  SPI clock from master; mode 0; asynchronous to CLK; must be <= CLK/8.
- MOSI  input  1  SPI data from master.
- CSN  input  1  SPI chip select, active low.
- MISO  output  1  SPI data to master.
- i_accel_x  input  12  X sample, two's complement.
- i_accel_y  input  12  Y sample.
- i_accel_z  input  12  Z sample.
- i_sample_stb  input  1  one-CLK pulse: new sample present on i_accel_*.
- o_filter_ctl  output  8  FILTER_CTL register (0x2C).
- o_power_ctl  output  8  POWER_CTL register (0x2D).
- o_busy  output  1  high while synchronized CSN is low.

Behaviour:
- Reset: MISO=0, o_busy=0, o_filter_ctl=8'h13, o_power_ctl=8'h00, data_ready=0, shadow samples=0, state IDLE.
- Reset asserted mid-transaction aborts the transaction; no partial write commits.
- Sync: SCLK, MOSI and CSN pass through SYNC_STAGES flops, then edge detect. MOSI is sampled on the detected SCLK rise. MISO changes on the detected SCLK fall.
- Sample capture: on i_sample_stb, the i_accel_* values load into a pending register and data_ready is set.
- On the detected CSN fall, pending copies into a transaction shadow, so all bytes read in one transaction are coherent.
- Register map (read):
  - 0x00 DEVID_AD; 0x01 DEVID_MST; 0x02 PARTID.
  - 0x0B STATUS = {7'b0, data_ready}.
  - 0x0E/0x0F XDATA_L/H; 0x10/0x11 Y; 0x12/0x13 Z.
  - L = s[7:0]; H = {4{s[11]}, s[11:8]}.
  - Data registers read 0x00 unless o_power_ctl[1:0]==2'b10 (measure mode).
  - 0x2C, 0x2D return their register values; all other addresses read 0x00.
- Writable registers: 0x2C and 0x2D only; writes to any other address are discarded.
- FSM states: IDLE, CMD, ADDR, DATA_RD, DATA_WR, IGNORE.
  - IDLE -> CMD on CSN fall; bit counter cleared.
  - CMD: after 8 rising edges, 0x0B -> ADDR (read), 0x0A -> ADDR (write), anything else (including 0x0D FIFO) -> IGNORE.
  - ADDR: after 8 bits, latch addr and go to DATA_RD or DATA_WR.
  - DATA_RD: the byte at addr loads into the TX shift register when the address byte completes. Its MSB drives MISO on the next SCLK fall; subsequent bits follow on subsequent falls.
  - DATA_RD: each completed byte increments addr (8-bit wrap 0xFF->0x00) and reloads the shift register.
  - DATA_WR: each complete 8-bit byte commits to addr, then addr increments.
  - IGNORE: MISO=0 until CSN rises.
  - Any state -> IDLE on CSN rise. A partial byte is discarded; MISO=0 while in IDLE.
- data_ready clears on CSN rise of a read transaction that transferred a complete byte from any address in 0x0E–0x13.
- If i_sample_stb arrives on the same cycle as that clear, set wins.
- o_busy = inverted synchronized CSN.

Optional Feature:
- Macro ACL_RESP_SOFTRESET_EN.
- Defined: address 0x1F (SOFT_RESET) is writable. Writing 8'h52 returns o_filter_ctl, o_power_ctl and data_ready to reset values at CSN rise. Other values written to 0x1F are ignored; 0x1F reads 0x00.
- Undefined: writes to 0x1F are discarded like any unmapped address.

Decomposition:
- Package adxl362_pkg:
  - command codes CMD_WR=8'h0A, CMD_RD=8'h0B, CMD_FIFO=8'h0D;
  - register address constants;
  - FILTER_CTL reset value 8'h13;
  - SOFT_RESET key 8'h52;
  - FSM state encoding.
- Sub-module spi_sync_edge: SYNC_STAGES-deep synchronizer with rise/fall pulse outputs, instantiated for SCLK and CSN; MOSI uses the synchronizer only.

Test Plan:
- Read 0x0B,0x00 followed by 3 data bytes -> MISO returns 0xAD, 0x1D, 0xF2.
- Write 0x0A,0x2D,0x02, then read 0x2D -> o_power_ctl=8'h02 and read returns 0x02.
- In measure mode, strobe x=12'hF85, y=12'h07F, z=12'h400; read 6 bytes from 0x0E -> 0x85,0xFF,0x7F,0x00,0x00,0x04. STATUS reads 0x01 before and 0x00 after that transaction.
- Same sample with POWER_CTL=0x00 -> all six data bytes read 0x00.
- Write 0x0A,0x2C with CSN raised after 5 data bits -> o_filter_ctl stays 8'h13. Command 0x0D -> MISO stays 0 for 16 clocks.
- Read from 0xFF for 2 bytes -> 0x00 then 0xAD (wrap). With ACL_RESP_SOFTRESET_EN, write 0x52 to 0x1F after setting POWER_CTL=0x02 -> o_power_ctl returns to 0x00.

Source files
------------

// File: rtl/adxl362_spi_responder_pkg.sv
// Shared constants for the ADXL362 SPI responder: command codes, register map,
// reset values, FSM encoding and sample helpers.
package adxl362_pkg;

  localparam logic [7:0] CMD_WR   = 8'h0A;
  localparam logic [7:0] CMD_RD   = 8'h0B;
  localparam logic [7:0] CMD_FIFO = 8'h0D;

  localparam logic [7:0] ADDR_DEVID_AD   = 8'h00;
  localparam logic [7:0] ADDR_DEVID_MST  = 8'h01;
  localparam logic [7:0] ADDR_PARTID     = 8'h02;
  localparam logic [7:0] ADDR_STATUS     = 8'h0B;
  localparam logic [7:0] ADDR_XDATA_L    = 8'h0E;
  localparam logic [7:0] ADDR_XDATA_H    = 8'h0F;
  localparam logic [7:0] ADDR_YDATA_L    = 8'h10;
  localparam logic [7:0] ADDR_YDATA_H    = 8'h11;
  localparam logic [7:0] ADDR_ZDATA_L    = 8'h12;
  localparam logic [7:0] ADDR_ZDATA_H    = 8'h13;
  localparam logic [7:0] ADDR_SOFT_RESET = 8'h1F;
  localparam logic [7:0] ADDR_FILTER_CTL = 8'h2C;
  localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

  localparam logic [7:0] FILTER_CTL_RST = 8'h13;
  localparam logic [7:0] POWER_CTL_RST  = 8'h00;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_ADDR    = 3'd2;
  localparam logic [2:0] ST_DATA_RD = 3'd3;
  localparam logic [2:0] ST_DATA_WR = 3'd4;
  localparam logic [2:0] ST_IGNORE  = 3'd5;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] z;
  } accel_t;

  function automatic logic [7:0] data_lo(input logic [11:0] s);
    return s[7:0];
  endfunction

  function automatic logic [7:0] data_hi(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

  function automatic logic is_data_addr(input logic [7:0] a);
    return (a >= ADDR_XDATA_L) && (a <= ADDR_ZDATA_H);
  endfunction

endpackage

// File: rtl/adxl362_spi_responder_if.sv
// Accelerometer SPI pins; the controller is the master, this model the slave.
interface adxl362_spi_responder_if;
  logic SCLK;
  logic MOSI;
  logic CSN;
  logic MISO;

  modport master (output SCLK, output MOSI, output CSN, input MISO);
  modport slave  (input SCLK, input MOSI, input CSN, output MISO);
endinterface

// File: rtl/adxl362_spi_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with single-cycle
// rise/fall pulses derived from the synchronized value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/adxl362_spi_responder.sv
// ADXL362 SPI responder model (mode 0). Define ACL_RESP_SOFTRESET_EN to make
// the SOFT_RESET register (0x1F) functional.
module adxl362_spi_responder
  import adxl362_pkg::*;
#(
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] DEVID_MST   = 8'h1D,
  parameter logic [7:0] PARTID      = 8'hF2,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  adxl362_spi_responder_if.slave   spi,
  input  logic [11:0]              i_accel_x,
  input  logic [11:0]              i_accel_y,
  input  logic [11:0]              i_accel_z,
  input  logic                     i_sample_stb,
  output logic [7:0]               o_filter_ctl,
  output logic [7:0]               o_power_ctl,
  output logic                     o_busy
);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic csn_s, csn_rise, csn_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(CLK), .rst_n(rst_n), .d(spi.SCLK),
    .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
    .clk(CLK), .rst_n(rst_n), .d(spi.CSN),
    .q(csn_s), .rise(csn_rise), .fall(csn_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] addr_q, addr_d;
  logic       wr_q, wr_d;
  logic       miso_q, miso_d;
  logic [7:0] filter_q, filter_d;
  logic [7:0] power_q, power_d;
  logic       data_ready_q, data_ready_d;
  logic       rd_hit_q, rd_hit_d;
  accel_t     pending_q, pending_d;
  accel_t     shadow_q, shadow_d;
`ifdef ACL_RESP_SOFTRESET_EN
  logic       soft_pend_q, soft_pend_d;
`endif

  logic [7:0] rx_byte;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       measure;

  assign rx_byte = {rx_q, mosi_s};
  assign measure = (power_q[1:0] == 2'b10);

  // The address byte itself selects the first read; later bytes prefetch addr+1.
  always_comb begin
    rd_addr = (state_q == ST_ADDR) ? rx_byte : addr_q + 8'd1;
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_DEVID_AD:   rd_data = DEVID_AD;
      ADDR_DEVID_MST:  rd_data = DEVID_MST;
      ADDR_PARTID:     rd_data = PARTID;
      ADDR_STATUS:     rd_data = {7'b0, data_ready_q};
      ADDR_XDATA_L:    rd_data = data_lo(shadow_q.x) & {8{measure}};
      ADDR_XDATA_H:    rd_data = data_hi(shadow_q.x) & {8{measure}};
      ADDR_YDATA_L:    rd_data = data_lo(shadow_q.y) & {8{measure}};
      ADDR_YDATA_H:    rd_data = data_hi(shadow_q.y) & {8{measure}};
      ADDR_ZDATA_L:    rd_data = data_lo(shadow_q.z) & {8{measure}};
      ADDR_ZDATA_H:    rd_data = data_hi(shadow_q.z) & {8{measure}};
      ADDR_FILTER_CTL: rd_data = filter_q;
      ADDR_POWER_CTL:  rd_data = power_q;
      default:         rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    miso_d       = miso_q;
    filter_d     = filter_q;
    power_d      = power_q;
    data_ready_d = data_ready_q;
    rd_hit_d     = rd_hit_q;
    pending_d    = pending_q;
    shadow_d     = shadow_q;
`ifdef ACL_RESP_SOFTRESET_EN
    soft_pend_d  = soft_pend_q;
`endif

    if (i_sample_stb) begin
      pending_d.x = i_accel_x;
      pending_d.y = i_accel_y;
      pending_d.z = i_accel_z;
    end

    if (csn_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = 3'd0;
      shadow_d  = pending_q;
      rd_hit_d  = 1'b0;
      miso_d    = 1'b0;
`ifdef ACL_RESP_SOFTRESET_EN
      soft_pend_d = 1'b0;
`endif
    end else if (csn_rise) begin
      // Any partial byte in rx_q is simply dropped here.
      state_d = ST_IDLE;
      miso_d  = 1'b0;
      if (rd_hit_q) data_ready_d = 1'b0;
`ifdef ACL_RESP_SOFTRESET_EN
      if (soft_pend_q) begin
        filter_d     = FILTER_CTL_RST;
        power_d      = POWER_CTL_RST;
        data_ready_d = 1'b0;
        soft_pend_d  = 1'b0;
      end
`endif
    end else if (state_q != ST_IDLE) begin
      if (sclk_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            ST_CMD: begin
              if (rx_byte == CMD_RD) begin
                state_d = ST_ADDR;
                wr_d    = 1'b0;
              end else if (rx_byte == CMD_WR) begin
                state_d = ST_ADDR;
                wr_d    = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end
            ST_ADDR: begin
              addr_d = rx_byte;
              if (wr_q) begin
                state_d = ST_DATA_WR;
              end else begin
                state_d = ST_DATA_RD;
                tx_d    = rd_data;
              end
            end
            ST_DATA_RD: begin
              if (is_data_addr(addr_q)) rd_hit_d = 1'b1;
              addr_d = addr_q + 8'd1;
              tx_d   = rd_data;
            end
            ST_DATA_WR: begin
              case (addr_q)
                ADDR_FILTER_CTL: filter_d = rx_byte;
                ADDR_POWER_CTL:  power_d  = rx_byte;
`ifdef ACL_RESP_SOFTRESET_EN
                ADDR_SOFT_RESET: if (rx_byte == SOFT_RESET_KEY) soft_pend_d = 1'b1;
`endif
                default: ;
              endcase
              addr_d = addr_q + 8'd1;
            end
            default: ;
          endcase
        end
      end
      if (sclk_fall && state_q == ST_DATA_RD) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end

    // A new sample outranks a same-cycle clear.
    if (i_sample_stb) data_ready_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q  <= '0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      rx_q         <= '0;
      tx_q         <= '0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      miso_q       <= 1'b0;
      filter_q     <= FILTER_CTL_RST;
      power_q      <= POWER_CTL_RST;
      data_ready_q <= 1'b0;
      rd_hit_q     <= 1'b0;
      pending_q    <= '0;
      shadow_q     <= '0;
`ifdef ACL_RESP_SOFTRESET_EN
      soft_pend_q  <= 1'b0;
`endif
    end else begin
      mosi_sync_q  <= mosi_sync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      miso_q       <= miso_d;
      filter_q     <= filter_d;
      power_q      <= power_d;
      data_ready_q <= data_ready_d;
      rd_hit_q     <= rd_hit_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
`ifdef ACL_RESP_SOFTRESET_EN
      soft_pend_q  <= soft_pend_d;
`endif
    end
  end

  assign spi.MISO     = miso_q;
  assign o_busy       = ~csn_s;
  assign o_filter_ctl = filter_q;
  assign o_power_ctl  = power_q;

endmodule
